cache_tag_lookup: RTL

// - Control stage directly upstream of the 2-way tag RAM (new2_my_tag_ram). Drives its read/refill/LRU-write ports and consumes dout.
// - Runs the post-reset tag clear, accepts one CPU lookup at a time and compares both ways' tags. Hit: updates LRU. Miss: picks a victim, requests the line from memory, then writes the new tag.
// - tr_dout layout: [44]=LRU (victim way), [42:22]=way1 {valid,tag[19:0]}, [20:0]=way0 {valid,tag[19:0]}; bits 43 and 21 are 0.

---
 rtl/cache_tag_lookup.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cache_tag_lookup.sv
// Lookup/refill controller sitting in front of a 2-way tag RAM.
// Clears the tag RAM after reset, then serves one CPU lookup at a time, fetching missed lines from memory.
module cache_tag_lookup #(
  parameter int INDEX_W = 7,
  parameter int OFFS_W  = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic               rsp_way,
  output logic [INDEX_W-1:0] rsp_index,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_req_addr,
  output logic               mem_req_way,
  input  logic               mem_done,
  output logic [INDEX_W-1:0] tr_raddr,
  output logic [INDEX_W-1:0] tr_waddr,
  output logic [INDEX_W-1:0] tr_tag_bit_raddr,
  output logic               tr_re,
  output logic               tr_we,
  output logic               tr_refill,
  output logic               tr_select,
  output logic               tr_cache_reset,
  output logic [44:0]        tr_din,
  input  logic [44:0]        tr_dout
);

  localparam int LA_W   = 32 - OFFS_W;
  localparam int TAG_W  = 32 - INDEX_W - OFFS_W;
  localparam int STRIDE = 22;

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL} state_t;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] init_cnt_reg, init_cnt_next;
  logic [LA_W-1:0]    line_addr_reg, line_addr_next;
  logic               victim_reg, victim_next;
  logic [TAG_W:0]     field_reg [2];
  logic [TAG_W:0]     field_next [2];
  logic               fwd_valid_reg, fwd_valid_next;
  logic [INDEX_W-1:0] fwd_idx_reg, fwd_idx_next;
  logic               fwd_bit_reg, fwd_bit_next;

  logic [INDEX_W-1:0] line_idx, req_idx;
  logic [TAG_W-1:0]   line_tag;
  logic [TAG_W:0]     field_now [2];
  logic [TAG_W:0]     refill_field [2];
  logic [1:0]         way_valid, way_hit;
  logic               hit_any, hit_way, lru_now, victim_now;
  logic [44:0]        refill_din;
  logic               unused_bits;

  assign line_idx    = line_addr_reg[INDEX_W-1:0];
  assign line_tag    = line_addr_reg[LA_W-1 -: TAG_W];
  assign req_idx     = req_addr[OFFS_W +: INDEX_W];
  assign unused_bits = ^{req_addr[OFFS_W-1:0], tr_dout[43], tr_dout[21]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      assign field_now[gi]    = tr_dout[gi*STRIDE +: TAG_W+1];
      assign way_valid[gi]    = field_now[gi][TAG_W];
      assign way_hit[gi]      = way_valid[gi] && (field_now[gi][TAG_W-1:0] == line_tag);
      assign refill_field[gi] = (victim_reg == 1'(gi)) ? {1'b1, line_tag} : field_reg[gi];
    end
  endgenerate

  // The RAM read for a back-to-back lookup races the previous hit's LRU write to the same set.
  assign lru_now    = (fwd_valid_reg && fwd_idx_reg == line_idx) ? fwd_bit_reg : tr_dout[44];
  assign hit_any    = |way_hit;
  assign hit_way    = ~way_hit[0];
  assign victim_now = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_now);
  assign refill_din = {~victim_reg, 1'b0, refill_field[1], 1'b0, refill_field[0]};

  assign mem_req_addr = {line_addr_reg, {OFFS_W{1'b0}}};
  assign mem_req_way  = victim_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= INIT;
      init_cnt_reg  <= '0;
      line_addr_reg <= '0;
      victim_reg    <= 1'b0;
      field_reg[0]  <= '0;
      field_reg[1]  <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_idx_reg   <= '0;
      fwd_bit_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      line_addr_reg <= line_addr_next;
      victim_reg    <= victim_next;
      field_reg[0]  <= field_next[0];
      field_reg[1]  <= field_next[1];
      fwd_valid_reg <= fwd_valid_next;
      fwd_idx_reg   <= fwd_idx_next;
      fwd_bit_reg   <= fwd_bit_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    init_cnt_next    = init_cnt_reg;
    line_addr_next   = line_addr_reg;
    victim_next      = victim_reg;
    field_next[0]    = field_reg[0];
    field_next[1]    = field_reg[1];
    fwd_valid_next   = 1'b0;
    fwd_idx_next     = fwd_idx_reg;
    fwd_bit_next     = fwd_bit_reg;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_hit          = 1'b0;
    rsp_way          = 1'b0;
    rsp_index        = '0;
    mem_req_valid    = 1'b0;
    tr_raddr         = '0;
    tr_waddr         = '0;
    tr_tag_bit_raddr = '0;
    tr_re            = 1'b0;
    tr_we            = 1'b0;
    tr_refill        = 1'b0;
    tr_select        = 1'b0;
    tr_cache_reset   = 1'b1;
    tr_din           = '0;

    case (state_reg)
      INIT: begin
        tr_cache_reset = 1'b0;
        tr_raddr       = init_cnt_reg;
        init_cnt_next  = init_cnt_reg + 1'b1;
        if (init_cnt_reg == '1) state_next = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        tr_raddr  = req_idx;
        tr_re     = req_valid;
        if (req_valid) begin
          line_addr_next = req_addr[31:OFFS_W];
          state_next     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          rsp_valid        = 1'b1;
          rsp_hit          = 1'b1;
          rsp_way          = hit_way;
          rsp_index        = line_idx;
          tr_we            = 1'b1;
          tr_tag_bit_raddr = line_idx;
          tr_din[44]       = ~hit_way;
          fwd_valid_next   = 1'b1;
          fwd_idx_next     = line_idx;
          fwd_bit_next     = ~hit_way;
          req_ready        = 1'b1;
          tr_raddr         = req_idx;
          tr_re            = req_valid;
          if (req_valid) begin
            line_addr_next = req_addr[31:OFFS_W];
            state_next     = LOOKUP;
          end else begin
            state_next = IDLE;
          end
        end else begin
          field_next[0] = field_now[0];
          field_next[1] = field_now[1];
          victim_next   = victim_now;
          state_next    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_done) state_next = REFILL;
      end
      REFILL: begin
        tr_refill  = 1'b1;
        tr_select  = 1'b1;
        tr_waddr   = line_idx;
        tr_din     = refill_din;
        rsp_valid  = 1'b1;
        rsp_way    = victim_reg;
        rsp_index  = line_idx;
        state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

endmodule
